// File: rtl/udcnt_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package udcnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Out-of-range load values saturate to the top of the count range.
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulus);
    return (val < modulus) ? val : modulus - 32'd1;
  endfunction

  // Value at which a count in direction dir is about to wrap.
  function automatic int unsigned term_val(input logic dir, input int unsigned modulus);
    return (dir == DIR_UP) ? modulus - 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/udcnt_next_val.sv
// Combinational next-count and wrap detection for one enabled step.
module udcnt_next_val
  import udcnt_pkg::*;
#(
  parameter int BUS_WIDTH = 4,
  parameter int MODULUS   = 10
) (
  input  logic [BUS_WIDTH-1:0] cnt,
  input  logic                 up,
  output logic [BUS_WIDTH-1:0] next_cnt,
  output logic                 wrap
);

  // One bit wider so MODULUS == 2**BUS_WIDTH is not truncated.
  localparam logic [BUS_WIDTH:0] LAST = (BUS_WIDTH + 1)'(MODULUS - 1);

  always_comb begin
    next_cnt = cnt;
    wrap     = 1'b0;
    if (up == DIR_UP) begin
      if ({1'b0, cnt} == LAST) begin
        next_cnt = '0;
        wrap     = 1'b1;
      end else begin
        next_cnt = cnt + BUS_WIDTH'(1);
      end
    end else begin
      if (cnt == '0) begin
        next_cnt = LAST[BUS_WIDTH-1:0];
        wrap     = 1'b1;
      end else begin
        next_cnt = cnt - BUS_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/modulo_updown_counter.sv
// Runtime-direction modulo-N counter with clear, clamped load and cascade outputs.
// Define UDCNT_OVF_STICKY_EN to add the sticky wrap flag o_ovf.
module modulo_updown_counter
  import udcnt_pkg::*;
#(
  parameter int    BUS_WIDTH = 4,
  parameter int    MODULUS   = 10,
  parameter string INIT_DIR  = "up"
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sclr,
  input  logic                 i_load,
  input  logic [BUS_WIDTH-1:0] i_load_val,
  input  logic                 i_en,
  input  logic                 i_up,
  output logic [BUS_WIDTH-1:0] o_cnt,
  output logic                 o_tc,
  output logic                 o_carry,
  output logic                 o_wrap
`ifdef UDCNT_OVF_STICKY_EN
  ,
  output logic                 o_ovf
`endif
);

  // The helpers work in 32-bit arithmetic, which bounds the usable width.
  if (BUS_WIDTH < 1 || BUS_WIDTH > 31) begin : g_bad_width
    $error("modulo_updown_counter: BUS_WIDTH must be in 1..31");
  end
  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << BUS_WIDTH)) begin : g_bad_modulus
    $error("modulo_updown_counter: MODULUS must be in 2..2**BUS_WIDTH");
  end
  if (INIT_DIR != "up" && INIT_DIR != "down") begin : g_bad_dir
    $error("modulo_updown_counter: INIT_DIR must be \"up\" or \"down\"");
  end

  localparam int unsigned RESET_INT = (INIT_DIR == "down") ? 32'(MODULUS - 1) : 32'd0;
  localparam logic [BUS_WIDTH-1:0] RESET_VAL = BUS_WIDTH'(RESET_INT);

  logic [BUS_WIDTH-1:0] step_cnt;
  logic                 step_wrap;
  logic [BUS_WIDTH-1:0] clear_cnt;
  logic [BUS_WIDTH-1:0] load_cnt;

  udcnt_next_val #(
    .BUS_WIDTH(BUS_WIDTH),
    .MODULUS  (MODULUS)
  ) u_next_val (
    .cnt     (o_cnt),
    .up      (i_up),
    .next_cnt(step_cnt),
    .wrap    (step_wrap)
  );

  // A clear parks the count at the start of the current direction.
  assign clear_cnt = BUS_WIDTH'(term_val(~i_up, MODULUS));
  assign load_cnt  = BUS_WIDTH'(clamp_load(32'(i_load_val), MODULUS));
  assign o_tc      = (32'(o_cnt) == term_val(i_up, MODULUS));
  assign o_carry   = o_tc & i_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt  <= RESET_VAL;
      o_wrap <= 1'b0;
    end else if (i_sclr) begin
      o_cnt  <= clear_cnt;
      o_wrap <= 1'b0;
    end else if (i_load) begin
      o_cnt  <= load_cnt;
      o_wrap <= 1'b0;
    end else if (i_en) begin
      o_cnt  <= step_cnt;
      o_wrap <= step_wrap;
    end else begin
      o_wrap <= 1'b0;
    end
  end

`ifdef UDCNT_OVF_STICKY_EN
  // Only reset or clear drop the flag; loads leave it alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf <= 1'b0;
    end else if (i_sclr) begin
      o_ovf <= 1'b0;
    end else if (!i_load && i_en && step_wrap) begin
      o_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Self-checking bench: directed and random steps against an arithmetic model, plus two-stage cascades.
module tb_modulo_updown_counter;

  localparam int M = 10;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Main DUT: BUS_WIDTH=4, MODULUS=10, INIT_DIR="down"
  logic       a_rst = 1'b1, a_sclr = 1'b0, a_load = 1'b0, a_en = 1'b0, a_up = 1'b0;
  logic [3:0] a_val = '0;
  logic [3:0] a_cnt;
  logic       a_tc, a_carry, a_wrap;
`ifdef UDCNT_OVF_STICKY_EN
  logic       a_ovf;
`endif

  modulo_updown_counter #(.BUS_WIDTH(4), .MODULUS(M), .INIT_DIR("down")) dut_a (
    .i_clk(i_clk), .i_rst(a_rst), .i_sclr(a_sclr), .i_load(a_load), .i_load_val(a_val),
    .i_en(a_en), .i_up(a_up), .o_cnt(a_cnt), .o_tc(a_tc), .o_carry(a_carry), .o_wrap(a_wrap)
`ifdef UDCNT_OVF_STICKY_EN
    , .o_ovf(a_ovf)
`endif
  );

  // Cascades: a decimal pair (0..99) and a full-range hex pair (0..255)
  logic       c_rst = 1'b1, c_zero = 1'b0, c_up = 1'b1, c10_en = 1'b0, c16_en = 1'b0;
  logic [3:0] c_val = '0;
  logic [3:0] c10_lo, c10_hi, c16_lo, c16_hi;
  logic       c10_tc0, c10_carry0, c10_wrap0, c10_tc1, c10_carry1, c10_wrap1;
  logic       c16_tc0, c16_carry0, c16_wrap0, c16_tc1, c16_carry1, c16_wrap1;
`ifdef UDCNT_OVF_STICKY_EN
  logic       c10_ovf0, c10_ovf1, c16_ovf0, c16_ovf1;
`endif

  modulo_updown_counter #(.BUS_WIDTH(4), .MODULUS(10), .INIT_DIR("up")) c10_s0 (
    .i_clk(i_clk), .i_rst(c_rst), .i_sclr(c_zero), .i_load(c_zero), .i_load_val(c_val),
    .i_en(c10_en), .i_up(c_up), .o_cnt(c10_lo), .o_tc(c10_tc0), .o_carry(c10_carry0), .o_wrap(c10_wrap0)
`ifdef UDCNT_OVF_STICKY_EN
    , .o_ovf(c10_ovf0)
`endif
  );
  modulo_updown_counter #(.BUS_WIDTH(4), .MODULUS(10), .INIT_DIR("up")) c10_s1 (
    .i_clk(i_clk), .i_rst(c_rst), .i_sclr(c_zero), .i_load(c_zero), .i_load_val(c_val),
    .i_en(c10_carry0), .i_up(c_up), .o_cnt(c10_hi), .o_tc(c10_tc1), .o_carry(c10_carry1), .o_wrap(c10_wrap1)
`ifdef UDCNT_OVF_STICKY_EN
    , .o_ovf(c10_ovf1)
`endif
  );
  modulo_updown_counter #(.BUS_WIDTH(4), .MODULUS(16), .INIT_DIR("up")) c16_s0 (
    .i_clk(i_clk), .i_rst(c_rst), .i_sclr(c_zero), .i_load(c_zero), .i_load_val(c_val),
    .i_en(c16_en), .i_up(c_up), .o_cnt(c16_lo), .o_tc(c16_tc0), .o_carry(c16_carry0), .o_wrap(c16_wrap0)
`ifdef UDCNT_OVF_STICKY_EN
    , .o_ovf(c16_ovf0)
`endif
  );
  modulo_updown_counter #(.BUS_WIDTH(4), .MODULUS(16), .INIT_DIR("up")) c16_s1 (
    .i_clk(i_clk), .i_rst(c_rst), .i_sclr(c_zero), .i_load(c_zero), .i_load_val(c_val),
    .i_en(c16_carry0), .i_up(c_up), .o_cnt(c16_hi), .o_tc(c16_tc1), .o_carry(c16_carry1), .o_wrap(c16_wrap1)
`ifdef UDCNT_OVF_STICKY_EN
    , .o_ovf(c16_ovf1)
`endif
  );

  // Reference model state for dut_a
  int m_cnt  = M - 1;
  bit m_wrap = 1'b0;
  bit m_ovf  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Count moves by +/-1 modulo M; stepping outside 0..M-1 is a wrap.
  task automatic modelEdge(input bit sclr, load, input int val, input bit en, up);
    int nxt;
    m_wrap = 1'b0;
    if (sclr) begin
      m_cnt = up ? 0 : M - 1;
      m_ovf = 1'b0;
    end else if (load) begin
      m_cnt = (val < M) ? val : M - 1;
    end else if (en) begin
      nxt    = m_cnt + (up ? 1 : -1);
      m_wrap = (nxt < 0) || (nxt >= M);
      m_cnt  = (nxt + M) % M;
      if (m_wrap) m_ovf = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit sclr, load, input int val, input bit en, up);
    bit exp_tc;
    a_sclr = sclr; a_load = load; a_val = 4'(val); a_en = en; a_up = up;
    #1;
    exp_tc = up ? (m_cnt == M - 1) : (m_cnt == 0);
    checkOutput("tc", 32'(a_tc), 32'(exp_tc));
    checkOutput("carry", 32'(a_carry), 32'(exp_tc & en));
    @(posedge i_clk);
    #1;
    modelEdge(sclr, load, val, en, up);
    checkOutput("cnt", 32'(a_cnt), 32'(m_cnt));
    checkOutput("wrap", 32'(a_wrap), 32'(m_wrap));
`ifdef UDCNT_OVF_STICKY_EN
    checkOutput("ovf", 32'(a_ovf), 32'(m_ovf));
`endif
  endtask

  initial begin
    int wraps;
    $display("[TB] start");

    // Reset value for INIT_DIR="down" while reset is held
    #12;
    checkOutput("reset_cnt", 32'(a_cnt), 32'(M - 1));
    checkOutput("reset_wrap", 32'(a_wrap), 32'd0);
    a_rst = 1'b0;
    c_rst = 1'b0;

    // Clear upward, then twelve enabled up steps through the 9 -> 0 wrap
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 1);

    // Down from 2 through 0 -> 9, then reverse to 0 with a wrap
    applyStimulus(0, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);

    // Mid-count reversal has no dead cycle
    applyStimulus(0, 1, 5, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);

    // Load clamp and priority
    applyStimulus(0, 1, 13, 0, 1);
    applyStimulus(1, 1, 4, 1, 0);
    applyStimulus(0, 1, 4, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Sticky flag: set by a wrap, kept through a load, cleared by clear at a wrap point
    applyStimulus(0, 1, 9, 0, 1);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 1, 3, 0, 1);
    applyStimulus(0, 1, 9, 0, 1);
    applyStimulus(1, 0, 0, 1, 1);

    // Asynchronous reset mid-cycle, no clock edge involved
    applyStimulus(0, 1, 4, 0, 1);
    #2;
    a_rst = 1'b1;
    #1;
    m_cnt = M - 1; m_wrap = 1'b0; m_ovf = 1'b0;
    checkOutput("async_rst_cnt", 32'(a_cnt), 32'(m_cnt));
    checkOutput("async_rst_wrap", 32'(a_wrap), 32'd0);
`ifdef UDCNT_OVF_STICKY_EN
    checkOutput("async_rst_ovf", 32'(a_ovf), 32'd0);
`endif
    #1;
    a_rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    // Decimal cascade 00..99 -> 00
    c10_en = 1'b1;
    wraps  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge i_clk);
      #1;
      if (c10_wrap1) wraps++;
      checkOutput("casc10_cnt", 32'(c10_hi) * 10 + 32'(c10_lo), 32'(k % 100));
    end
    c10_en = 1'b0;
    checkOutput("casc10_wrap_pulses", 32'(wraps), 32'd1);

    // Full-range hex cascade 00..FF -> 00
    c16_en = 1'b1;
    wraps  = 0;
    for (int k = 1; k <= 256; k++) begin
      @(posedge i_clk);
      #1;
      if (c16_wrap1) wraps++;
      checkOutput("casc16_cnt", 32'(c16_hi) * 16 + 32'(c16_lo), 32'(k % 256));
    end
    c16_en = 1'b0;
    checkOutput("casc16_wrap_pulses", 32'(wraps), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
